// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Rotates one BCD code at a time to a shared registered decoder, with anode blanking, frame snapshot and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NDIG        = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [4*NDIG-1:0] DIGITS,
  output logic [3:0]        D,
  output logic [NDIG-1:0]   AN,
  output logic [2:0]        DIG_IDX,
  output logic              FRAME
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int              CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       IDX_LAST  = 3'(NDIG - 1);
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx_nxt;
  logic [4*NDIG-1:0] snap, snap_nxt;
  logic [3:0]        d_nxt;
  logic [NDIG-1:0]   an_nxt;
  logic              frame_nxt;
  logic              boundary;

  // Code shown for digit idx of value v; a digit is blanked when it and every
  // higher digit are zero, except digit 0 which always shows.
  function automatic logic [3:0] display_code(input logic [4*NDIG-1:0] v,
                                              input logic [2:0]        idx);
    logic       zero_above;
    logic [3:0] code;
    zero_above = 1'b1;
    code       = BLANK_CODE;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above & (v[4*i +: 4] == 4'h0);
      if (3'(i) == idx)
        code = (LZ_SUPPRESS != 0 && i != 0 && zero_above) ? BLANK_CODE : v[4*i +: 4];
    end
    return code;
  endfunction

  // State register: every output is a flop, loaded with the value it must
  // show in the following cycle.
  // NOTE: sequential state uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      DIG_IDX <= IDX_LAST;
      snap    <= '0;
      D       <= BLANK_CODE;
      AN      <= '1;
      FRAME   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      DIG_IDX <= idx_nxt;
      snap    <= snap_nxt;
      D       <= d_nxt;
      AN      <= an_nxt;
      FRAME   <= frame_nxt;
    end
  end

  // Next-state: slot boundary advances the digit; leaving EN drops straight to IDLE.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = DIG_IDX;
    snap_nxt  = snap;
    boundary  = EN && (state == IDLE || cnt == CNT_LAST);

    if (!EN) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = IDX_LAST;
    end else if (boundary) begin
      state_nxt = SCAN;
      cnt_nxt   = '0;
      idx_nxt   = (DIG_IDX >= IDX_LAST) ? 3'd0 : DIG_IDX + 3'd1;
      if (idx_nxt == 3'd0)
        snap_nxt = DIGITS;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Outputs derived from next-state values so the registered pins line up with cnt.
  always_comb begin
    d_nxt     = BLANK_CODE;
    an_nxt    = '1;
    frame_nxt = 1'b0;
    if (state_nxt == SCAN) begin
      d_nxt = boundary ? display_code(snap_nxt, idx_nxt) : D;
      // Anodes stay dark while the decoder still holds the previous digit.
      if (cnt_nxt > CNT_BLANK)
        an_nxt = ~(NDIG'(1) << idx_nxt);
      frame_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model, randomized
// stimulus, and a registered-decoder monitor for anode exclusivity and segment alignment.
module tb_seg_scan_ctrl;

  localparam int NDIG        = 4;
  localparam int SCAN_DIV    = 8;
  localparam int BLANK_CYC   = 2;
  localparam int LZ_SUPPRESS = 1;
  localparam int FRAME_LEN   = NDIG * SCAN_DIV;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              EN  = 1'b0;
  logic [4*NDIG-1:0] DIGITS = '0;
  logic [3:0]        D;
  logic [NDIG-1:0]   AN;
  logic [2:0]        DIG_IDX;
  logic              FRAME;

  int checks = 0;
  int errors = 0;
  int mon_errors = 0;
  bit mon_en = 1'b0;

  seg_scan_ctrl #(
    .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_SUPPRESS(LZ_SUPPRESS)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIGITS(DIGITS),
    .D(D), .AN(AN), .DIG_IDX(DIG_IDX), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Shown code for a slot: everything above the most significant non-zero digit blanks.
  function automatic logic [3:0] shown(input logic [15:0] v, input int slot);
    int msd;
    msd = -1;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] != 4'h0) msd = i;
    if (LZ_SUPPRESS == 0 || slot == 0 || slot <= msd) return v[4*slot +: 4];
    return 4'hF;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: position p within the running frame plus the frame's snapshot.
  bit          running = 1'b0;
  int          p = 0;
  logic [15:0] snap_m = '0;

  always @(posedge CLK) begin
    if (RST) begin
      running <= 1'b0;
      p       <= 0;
      snap_m  <= '0;
    end else if (!EN) begin
      running <= 1'b0;
      p       <= 0;
    end else if (!running) begin
      running <= 1'b1;
      p       <= 0;
      snap_m  <= DIGITS;
    end else begin
      p <= (p + 1) % FRAME_LEN;
      if ((p + 1) % FRAME_LEN == 0) snap_m <= DIGITS;
    end
  end

  logic [NDIG-1:0] exp_an;
  logic [3:0]      exp_d;
  logic [2:0]      exp_idx;
  logic            exp_frame;
  int              exp_slot;

  always_comb begin
    exp_an    = '1;
    exp_d     = 4'hF;
    exp_idx   = 3'(NDIG - 1);
    exp_frame = 1'b0;
    exp_slot  = p / SCAN_DIV;
    if (running) begin
      exp_idx   = 3'(exp_slot);
      exp_d     = shown(snap_m, exp_slot);
      if (p % SCAN_DIV > BLANK_CYC) exp_an[exp_slot] = 1'b0;
      exp_frame = (p == FRAME_LEN - 1);
    end
  end

  // Shared decoder stand-in (registered) and per-cycle display invariants.
  logic [6:0] seg = 7'h7F;
  always @(posedge CLK) seg <= seg7(D);

  always @(negedge CLK) begin
    if (mon_en) begin
      if ($isunknown(AN) || $countones(~AN) > 1) begin
        mon_errors <= mon_errors + 1;
        $display("FAIL anode_onehot t=%0t AN=%b (at most one low required)", $time, AN);
      end else if (AN != '1 && seg !== seg7(shown(snap_m, int'(exp_idx)))) begin
        mon_errors <= mon_errors + 1;
        $display("FAIL seg_align t=%0t seg=%h required %h", $time, seg,
                 seg7(shown(snap_m, int'(exp_idx))));
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; DIGITS = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (AN !== 4'hF || D !== 4'hF || DIG_IDX !== 3'd3 || FRAME !== 1'b0) begin
        errors++;
        $display("FAIL reset k=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=1111 D=f IDX=3 FR=0",
                 k, AN, D, DIG_IDX, FRAME);
      end
    end
    RST = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] d_tab  [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    int nframes = 0, first_fr = -1, last_fr = -1;
    for (int k = 0; k < 2 * FRAME_LEN; k++) begin
      cycle();
      checks++;
      if ({AN, D, DIG_IDX, FRAME} !== {exp_an, exp_d, exp_idx, exp_frame}) begin
        errors++;
        $display("FAIL basic k=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=%b D=%h IDX=%0d FR=%b",
                 k, AN, D, DIG_IDX, FRAME, exp_an, exp_d, exp_idx, exp_frame);
      end
      if (k == 2) begin
        checks++;
        if (AN !== 4'hF) begin
          errors++;
          $display("FAIL basic_blank_edge got AN=%b want 1111", AN);
        end
      end
      if (k % SCAN_DIV == BLANK_CYC + 1 && k < FRAME_LEN) begin
        checks++;
        if (AN !== an_tab[k/SCAN_DIV] || D !== d_tab[k/SCAN_DIV]) begin
          errors++;
          $display("FAIL basic_slot%0d got AN=%b D=%h want AN=%b D=%h",
                   k / SCAN_DIV, AN, D, an_tab[k/SCAN_DIV], d_tab[k/SCAN_DIV]);
        end
      end
      if (FRAME === 1'b1) begin
        nframes++;
        if (first_fr < 0) first_fr = k;
        last_fr = k;
      end
    end
    checks++;
    if (nframes != 2 || first_fr != FRAME_LEN - 1 || last_fr != 2 * FRAME_LEN - 1) begin
      errors++;
      $display("FAIL frame_pulse got count=%0d first=%0d last=%0d want 2/%0d/%0d",
               nframes, first_fr, last_fr, FRAME_LEN - 1, 2 * FRAME_LEN - 1);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0070, 16'h0000, 16'h1000};
    logic [15:0] seqs [3] = '{16'hFF70, 16'hFFF0, 16'h1000};
    logic [15:0] got;
    for (int t = 0; t < 3; t++) begin
      EN = 1'b0; DIGITS = vals[t];
      cycle();
      EN = 1'b1;
      got = '0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        cycle();
        checks++;
        if ({AN, D, DIG_IDX, FRAME} !== {exp_an, exp_d, exp_idx, exp_frame}) begin
          errors++;
          $display("FAIL lz k=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=%b D=%h IDX=%0d FR=%b",
                   k, AN, D, DIG_IDX, FRAME, exp_an, exp_d, exp_idx, exp_frame);
        end
        if (k % SCAN_DIV == 0) got[4*(k/SCAN_DIV) +: 4] = D;
      end
      checks++;
      if (got !== seqs[t]) begin
        errors++;
        $display("FAIL lz_seq digits=%h got slots3..0=%h want %h", vals[t], got, seqs[t]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] got = '0;
    EN = 1'b0; DIGITS = 16'h1234;
    cycle();
    EN = 1'b1;
    for (int k = 0; k < 2 * FRAME_LEN; k++) begin
      cycle();
      checks++;
      if ({AN, D, DIG_IDX, FRAME} !== {exp_an, exp_d, exp_idx, exp_frame}) begin
        errors++;
        $display("FAIL snap k=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=%b D=%h IDX=%0d FR=%b",
                 k, AN, D, DIG_IDX, FRAME, exp_an, exp_d, exp_idx, exp_frame);
      end
      if (k % SCAN_DIV == 0) got[4*(k/SCAN_DIV) +: 4] = D;
      if (k == SCAN_DIV + 2) DIGITS = 16'h5678;
    end
    checks++;
    if (got !== 32'h5678_1234) begin
      errors++;
      $display("FAIL snapshot_seq got %h want 56781234", got);
    end
  endtask

  task automatic test_en_drop();
    EN = 1'b0; DIGITS = 16'h4321;
    cycle();
    EN = 1'b1;
    for (int k = 0; k <= 2 * SCAN_DIV + 4; k++) begin
      cycle();
      checks++;
      if ({AN, D, DIG_IDX, FRAME} !== {exp_an, exp_d, exp_idx, exp_frame}) begin
        errors++;
        $display("FAIL endrop_run k=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=%b D=%h IDX=%0d FR=%b",
                 k, AN, D, DIG_IDX, FRAME, exp_an, exp_d, exp_idx, exp_frame);
      end
    end
    EN = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      checks++;
      if (AN !== 4'hF || D !== 4'hF || DIG_IDX !== 3'd3 || FRAME !== 1'b0) begin
        errors++;
        $display("FAIL endrop_idle j=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=1111 D=f IDX=3 FR=0",
                 j, AN, D, DIG_IDX, FRAME);
      end
    end
    EN = 1'b1;
    cycle();
    checks++;
    if (DIG_IDX !== 3'd0 || D !== 4'h1 || AN !== 4'hF) begin
      errors++;
      $display("FAIL endrop_restart got IDX=%0d D=%h AN=%b want IDX=0 D=1 AN=1111", DIG_IDX, D, AN);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < NDIG; i++)
          v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        DIGITS = v;
      end
      if (EN) EN = ($urandom_range(0, 59) != 0);
      else    EN = ($urandom_range(0, 3) == 0);
      RST = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if ({AN, D, DIG_IDX, FRAME} !== {exp_an, exp_d, exp_idx, exp_frame}) begin
        errors++;
        $display("FAIL random n=%0d got AN=%b D=%h IDX=%0d FR=%b want AN=%b D=%h IDX=%0d FR=%b",
                 n, AN, D, DIG_IDX, FRAME, exp_an, exp_d, exp_idx, exp_frame);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_monitor();
    checks++;
    if (mon_errors != 0) begin
      errors++;
      $display("FAIL monitor got %0d invariant violations want 0", mon_errors);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_snapshot();
    test_en_drop();
    test_random();
    cycle();
    test_monitor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
